// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared opcodes, flag indices and state encodings for the execution unit
package risc_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_INC = 4'h6;
  localparam logic [3:0] OP_DEC = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h8;
  localparam logic [3:0] OP_NEG = 4'h9;
  localparam logic [3:0] OP_SHR = 4'hA;
  localparam logic [3:0] OP_SHL = 4'hB;
  localparam logic [3:0] OP_ROR = 4'hC;
  localparam logic [3:0] OP_ROL = 4'hD;
  localparam logic [3:0] OP_LD  = 4'hE;
  localparam logic [3:0] OP_ST  = 4'hF;

  // flags port is {N,Z,C,V}
  localparam int FLG_V = 0;
  localparam int FLG_C = 1;
  localparam int FLG_Z = 2;
  localparam int FLG_N = 3;

  typedef enum logic {
    S_RUN = 1'b0,
    S_MEM = 1'b1
  } state_t;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/risc_alu_p.sv
// rtl/risc_alu_p.sv - combinational ALU producing result, carry/borrow and signed overflow
module risc_alu_p
  import risc_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [3:0]    opcode,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          c,
  output logic          v
);

  localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

  logic [DW-1:0] x;
  logic [DW-1:0] y;
  logic          is_sub;
  logic [DW:0]   sum;
  logic          ovf;

  // All arithmetic ops share one adder/subtractor; inc/dec/neg just pick operands.
  always_comb begin
    x      = a;
    y      = b;
    is_sub = 1'b0;
    case (opcode)
      OP_INC: y = ONE;
      OP_SUB: is_sub = 1'b1;
      OP_DEC: begin
        y      = ONE;
        is_sub = 1'b1;
      end
      OP_NEG: begin
        x      = '0;
        y      = a;
        is_sub = 1'b1;
      end
      default: ;
    endcase
  end

  assign sum = is_sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
  assign ovf = is_sub ? ((x[DW-1] != y[DW-1]) && (sum[DW-1] != x[DW-1]))
                      : ((x[DW-1] == y[DW-1]) && (sum[DW-1] != x[DW-1]));

  always_comb begin
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_NEG: begin
        result = sum[DW-1:0];
        c      = sum[DW];
        v      = ovf;
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHR: begin
        result = {1'b0, a[DW-1:1]};
        c      = a[0];
      end
      OP_SHL: begin
        result = {a[DW-2:0], 1'b0};
        c      = a[DW-1];
      end
      OP_ROR: begin
        result = {a[0], a[DW-1:1]};
        c      = a[0];
      end
      OP_ROL: begin
        result = {a[DW-2:0], a[DW-1]};
        c      = a[DW-1];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/risc_eunit_p.sv
// rtl/risc_eunit_p.sv - execution unit: single-cycle ALU, LD/ST memory handshake with timeout, NZCV flags
module risc_eunit_p
  import risc_pkg::*;
#(
  parameter int DW      = 8,
  parameter int AW      = 4,
  parameter int RW      = 3,
  parameter int MEM_TMO = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [3:0]    opcode,
  input  logic [AW-1:0] dmaddrin,
  input  logic [DW-1:0] oprnd_a,
  input  logic [DW-1:0] oprnd_b,
  input  logic [RW-1:0] dstin,
  input  logic          dm_ack,
  output logic          dmenbl,
  output logic          rdwr,
  output logic [AW-1:0] dmaddr,
  output logic [DW-1:0] dmdatain,
  output logic [DW-1:0] rslt,
  output logic [RW-1:0] dst,
  output logic          reg_wr_vld,
  output logic          load_op,
  output logic [3:0]    flags,
  output logic          mem_err
);

  localparam int CW = $clog2(MEM_TMO + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(MEM_TMO - 1);

  state_t        state;
  logic [CW-1:0] tmo_cnt;
  logic [RW-1:0] mem_dst;
  logic [DW-1:0] alu_res;
  logic          alu_c;
  logic          alu_v;

  risc_alu_p #(.DW(DW)) u_alu (
    .opcode (opcode),
    .a      (oprnd_a),
    .b      (oprnd_b),
    .result (alu_res),
    .c      (alu_c),
    .v      (alu_v)
  );

  assign in_rdy = rst_n && (state == S_RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_RUN;
      tmo_cnt    <= '0;
      mem_dst    <= '0;
      dmenbl     <= 1'b0;
      rdwr       <= 1'b0;
      dmaddr     <= '0;
      dmdatain   <= '0;
      rslt       <= '0;
      dst        <= '0;
      reg_wr_vld <= 1'b0;
      load_op    <= 1'b0;
      flags      <= '0;
      mem_err    <= 1'b0;
    end else begin
      reg_wr_vld <= 1'b0;
      load_op    <= 1'b0;
      mem_err    <= 1'b0;
      if (state == S_RUN) begin
        if (in_vld && is_mem_op(opcode)) begin
          state   <= S_MEM;
          tmo_cnt <= '0;
          dmenbl  <= 1'b1;
          rdwr    <= (opcode == OP_LD);
          dmaddr  <= dmaddrin;
          mem_dst <= dstin;
          if (opcode == OP_ST) dmdatain <= oprnd_a;
        end else if (in_vld && opcode != OP_NOP) begin
          rslt         <= alu_res;
          dst          <= dstin;
          reg_wr_vld   <= 1'b1;
          flags[FLG_N] <= alu_res[DW-1];
          flags[FLG_Z] <= (alu_res == '0);
          flags[FLG_C] <= alu_c;
          flags[FLG_V] <= alu_v;
        end
      end else begin
        // An ack arriving on the expiry edge still completes the access.
        if (dm_ack) begin
          state  <= S_RUN;
          dmenbl <= 1'b0;
          if (rdwr) begin
            reg_wr_vld <= 1'b1;
            load_op    <= 1'b1;
            dst        <= mem_dst;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          state   <= S_RUN;
          dmenbl  <= 1'b0;
          mem_err <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_risc_eunit_p.sv
// tb/tb_risc_eunit_p.sv - self-checking bench for risc_eunit_p with a behavioural ALU model
module tb_risc_eunit_p;
  import risc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_vld = 1'b0;
  logic       in_rdy;
  logic [3:0] opcode = '0;
  logic [3:0] dmaddrin = '0;
  logic [7:0] oprnd_a = '0;
  logic [7:0] oprnd_b = '0;
  logic [2:0] dstin = '0;
  logic       dm_ack = 1'b0;
  logic       dmenbl, rdwr;
  logic [3:0] dmaddr;
  logic [7:0] dmdatain, rslt;
  logic [2:0] dst;
  logic       reg_wr_vld, load_op, mem_err;
  logic [3:0] flags;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_rslt = '0;
  logic [3:0] m_flags = '0;
  logic [2:0] m_dst = '0;

  risc_eunit_p #(.DW(8), .AW(4), .RW(3), .MEM_TMO(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .opcode(opcode),
    .dmaddrin(dmaddrin), .oprnd_a(oprnd_a), .oprnd_b(oprnd_b), .dstin(dstin),
    .dm_ack(dm_ack), .dmenbl(dmenbl), .rdwr(rdwr), .dmaddr(dmaddr), .dmdatain(dmdatain),
    .rslt(rslt), .dst(dst), .reg_wr_vld(reg_wr_vld), .load_op(load_op), .flags(flags),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Reference: integer arithmetic on unsigned/signed values, returns {result, N, Z, C, V}
  function automatic logic [11:0] model(input int op, input int a, input int b);
    int r, c, v, sa, sb, sr;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    r = 0; c = 0; v = 0;
    case (op)
      1:  begin r = a + b; c = (r > 255); sr = sa + sb; v = (sr > 127 || sr < -128); end
      2:  begin r = a - b; c = (a < b);   sr = sa - sb; v = (sr > 127 || sr < -128); end
      3:  r = a & b;
      4:  r = a | b;
      5:  r = a ^ b;
      6:  begin r = a + 1; c = (r > 255); v = (sa + 1 > 127); end
      7:  begin r = a - 1; c = (a == 0);  v = (sa - 1 < -128); end
      8:  r = 255 - a;
      9:  begin r = 0 - a; c = (a != 0);  v = (-sa > 127); end
      10: begin r = a / 2; c = a % 2; end
      11: begin r = a * 2; c = a / 128; end
      12: begin r = a / 2 + (a % 2) * 128; c = a % 2; end
      13: begin r = a * 2 + a / 128; c = a / 128; end
      default: r = 0;
    endcase
    r = r & 255;
    return {r[7:0], r >= 128, r == 0, c != 0, v != 0};
  endfunction

  task automatic issue(input logic vld, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [2:0] d, input logic [3:0] addr);
    @(negedge clk);
    in_vld = vld; opcode = op; oprnd_a = a; oprnd_b = b; dstin = d; dmaddrin = addr;
    @(posedge clk); #1;
  endtask

  task automatic tick(input logic ack);
    @(negedge clk);
    in_vld = 1'b0; dm_ack = ack;
    @(posedge clk); #1;
  endtask

  task automatic alu_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [2:0] d);
    logic [11:0] e;
    issue(1'b1, op, a, b, d, 4'h0);
    e = model(op, a, b);
    m_rslt = e[11:4]; m_flags = e[3:0]; m_dst = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(1'b0);
    tick(1'b0);
    checks++;
    if ({in_rdy, dmenbl, rdwr, dmaddr, dmdatain, rslt, dst, reg_wr_vld, load_op, flags, mem_err} !== 36'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0",
               {in_rdy, dmenbl, rdwr, dmaddr, dmdatain, rslt, dst, reg_wr_vld, load_op, flags, mem_err});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_release_rdy: got %b want 1", in_rdy); end
  endtask

  task automatic test_alu_directed();
    logic [7:0] ea [3] = '{8'hFF, 8'h80, 8'h56};
    logic [3:0] ef [3] = '{4'b1000, 4'b1001, 4'b0010};
    logic [3:0] op [3] = '{OP_ADD, OP_ADD, OP_SUB};
    logic [7:0] a  [3] = '{8'h00, 8'h7F, 8'h22};
    logic [7:0] b  [3] = '{8'hFF, 8'h01, 8'hCC};
    for (int i = 0; i < 3; i++) begin
      alu_op(op[i], a[i], b[i], 3'(i));
      checks++;
      if ({rslt, flags, dst, reg_wr_vld} !== {ea[i], ef[i], 3'(i), 1'b1}) begin
        errors++;
        $display("FAIL alu_directed_%0d: got rslt=%h flags=%b dst=%0d wr=%b want rslt=%h flags=%b dst=%0d wr=1",
                 i, rslt, flags, dst, reg_wr_vld, ea[i], ef[i], i);
      end
      tick(1'b0);
      checks++;
      if ({reg_wr_vld, rslt} !== {1'b0, ea[i]}) begin
        errors++;
        $display("FAIL alu_wr_drop_%0d: got wr=%b rslt=%h want wr=0 rslt=%h", i, reg_wr_vld, rslt, ea[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] op [3] = '{OP_SHL, OP_ROR, OP_ROL};
    logic [7:0] a  [3] = '{8'h44, 8'hEE, 8'h66};
    logic [7:0] ea [3] = '{8'h88, 8'h77, 8'hCC};
    logic [3:0] ef [3] = '{4'b1000, 4'b0000, 4'b1000};
    for (int i = 0; i < 3; i++) begin
      alu_op(op[i], a[i], 8'h00, 3'(i + 4));
      checks++;
      if ({rslt, flags, reg_wr_vld} !== {ea[i], ef[i], 1'b1}) begin
        errors++;
        $display("FAIL b2b_%0d: got rslt=%h flags=%b wr=%b want rslt=%h flags=%b wr=1",
                 i, rslt, flags, reg_wr_vld, ea[i], ef[i]);
      end
    end
    tick(1'b0);
    checks++;
    if ({reg_wr_vld, rslt} !== {1'b0, 8'hCC}) begin
      errors++; $display("FAIL b2b_end: got wr=%b rslt=%h want wr=0 rslt=cc", reg_wr_vld, rslt);
    end
  endtask

  task automatic test_random_alu();
    logic       vld;
    logic [3:0] op;
    logic [7:0] a, b;
    logic [2:0] d;
    logic       exp_wr;
    for (int i = 0; i < 80; i++) begin
      vld = ($urandom_range(0, 3) != 0);
      op  = 4'($urandom_range(0, 13));
      a   = 8'($urandom); b = 8'($urandom); d = 3'($urandom);
      if (i < 8) begin a = (i % 2 == 0) ? 8'h80 : 8'h00; b = (i % 4 < 2) ? 8'hFF : 8'h7F; end
      dm_ack = 1'($urandom);
      exp_wr = vld && (op != OP_NOP);
      if (exp_wr) alu_op(op, a, b, d);
      else issue(vld, op, a, b, d, 4'h0);
      checks++;
      if ({rslt, flags, dst, reg_wr_vld, load_op, mem_err, dmenbl, in_rdy} !==
          {m_rslt, m_flags, m_dst, exp_wr, 1'b0, 1'b0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL random_%0d op=%h a=%h b=%h: got rslt=%h flags=%b dst=%0d wr=%b want rslt=%h flags=%b dst=%0d wr=%b",
                 i, op, a, b, rslt, flags, dst, reg_wr_vld, m_rslt, m_flags, m_dst, exp_wr);
      end
    end
    dm_ack = 1'b0;
  endtask

  task automatic test_load();
    issue(1'b1, OP_LD, 8'h11, 8'h22, 3'd3, 4'h5);
    checks++;
    if ({dmenbl, rdwr, dmaddr, in_rdy, reg_wr_vld} !== {1'b1, 1'b1, 4'h5, 1'b0, 1'b0}) begin
      errors++; $display("FAIL ld_request: got en=%b rd=%b addr=%h rdy=%b wr=%b want 1 1 5 0 0",
                         dmenbl, rdwr, dmaddr, in_rdy, reg_wr_vld);
    end
    for (int i = 0; i < 2; i++) begin
      issue(1'b1, OP_ST, 8'hA5, 8'h00, 3'd7, 4'h9);
      checks++;
      if ({dmenbl, rdwr, dmaddr, in_rdy, reg_wr_vld, rslt, flags} !==
          {1'b1, 1'b1, 4'h5, 1'b0, 1'b0, m_rslt, m_flags}) begin
        errors++; $display("FAIL ld_hold_%0d: got en=%b rd=%b addr=%h rdy=%b wr=%b want 1 1 5 0 0",
                           i, dmenbl, rdwr, dmaddr, in_rdy, reg_wr_vld);
      end
    end
    @(negedge clk); dm_ack = 1'b1;
    @(posedge clk); #1;
    m_dst = 3'd3;
    checks++;
    if ({dmenbl, reg_wr_vld, load_op, dst, in_rdy, flags, rslt, mem_err} !==
        {1'b0, 1'b1, 1'b1, 3'd3, 1'b1, m_flags, m_rslt, 1'b0}) begin
      errors++; $display("FAIL ld_complete: got en=%b wr=%b ld=%b dst=%0d rdy=%b flags=%b want 0 1 1 3 1 %b",
                         dmenbl, reg_wr_vld, load_op, dst, in_rdy, flags, m_flags);
    end
    tick(1'b0);
    checks++;
    if ({reg_wr_vld, load_op, dst, dmenbl} !== {1'b0, 1'b0, 3'd3, 1'b0}) begin
      errors++; $display("FAIL ld_after: got wr=%b ld=%b dst=%0d en=%b want 0 0 3 0", reg_wr_vld, load_op, dst, dmenbl);
    end
  endtask

  task automatic test_store_timeout();
    issue(1'b1, OP_ST, 8'h5A, 8'h00, 3'd1, 4'hA);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({dmenbl, rdwr, dmdatain, dmaddr, mem_err, in_rdy} !== {1'b1, 1'b0, 8'h5A, 4'hA, 1'b0, 1'b0}) begin
        errors++; $display("FAIL st_wait_%0d: got en=%b rd=%b data=%h addr=%h err=%b rdy=%b want 1 0 5a a 0 0",
                           i, dmenbl, rdwr, dmdatain, dmaddr, mem_err, in_rdy);
      end
      tick(1'b0);
    end
    checks++;
    if ({dmenbl, mem_err, reg_wr_vld, in_rdy, flags, rslt} !== {1'b0, 1'b1, 1'b0, 1'b1, m_flags, m_rslt}) begin
      errors++; $display("FAIL st_timeout: got en=%b err=%b wr=%b rdy=%b want 0 1 0 1", dmenbl, mem_err, reg_wr_vld, in_rdy);
    end
    tick(1'b0);
    checks++;
    if (mem_err !== 1'b0) begin errors++; $display("FAIL st_err_pulse: got %b want 0", mem_err); end
    // ack on the same edge the timeout would expire
    issue(1'b1, OP_ST, 8'h3C, 8'h00, 3'd1, 4'h2);
    for (int i = 0; i < 3; i++) tick(1'b0);
    tick(1'b1);
    checks++;
    if ({dmenbl, mem_err, in_rdy, reg_wr_vld} !== {1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL st_ack_at_expiry: got en=%b err=%b rdy=%b wr=%b want 0 0 1 0", dmenbl, mem_err, in_rdy, reg_wr_vld);
    end
    tick(1'b0);
  endtask

  task automatic test_reset_in_mem();
    issue(1'b1, OP_LD, 8'h00, 8'h00, 3'd6, 4'h2);
    @(negedge clk); rst_n = 1'b0; in_vld = 1'b1; opcode = OP_ADD; dm_ack = 1'b1;
    @(posedge clk); #1;
    m_rslt = '0; m_flags = '0; m_dst = '0;
    checks++;
    if ({dmenbl, reg_wr_vld, load_op, flags, mem_err, rslt, dst, in_rdy} !== 20'h0) begin
      errors++; $display("FAIL rst_in_mem: got en=%b wr=%b ld=%b flags=%b err=%b rslt=%h rdy=%b want all 0",
                         dmenbl, reg_wr_vld, load_op, flags, mem_err, rslt, in_rdy);
    end
    @(negedge clk); rst_n = 1'b1; in_vld = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({in_rdy, reg_wr_vld, mem_err, dmenbl, load_op} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rst_recover: got rdy=%b wr=%b err=%b en=%b ld=%b want 1 0 0 0 0",
                         in_rdy, reg_wr_vld, mem_err, dmenbl, load_op);
    end
    tick(1'b0);
  endtask

  task automatic test_nop_st_ack();
    alu_op(OP_ADD, 8'hF0, 8'h20, 3'd2);
    issue(1'b1, OP_NOP, 8'h00, 8'h00, 3'd5, 4'h0);
    checks++;
    if ({rslt, flags, dst, reg_wr_vld} !== {m_rslt, m_flags, m_dst, 1'b0}) begin
      errors++; $display("FAIL nop_hold: got rslt=%h flags=%b dst=%0d wr=%b want %h %b %0d 0",
                         rslt, flags, dst, reg_wr_vld, m_rslt, m_flags, m_dst);
    end
    issue(1'b1, OP_ST, 8'h77, 8'h00, 3'd4, 4'h3);
    tick(1'b1);
    checks++;
    if ({rslt, flags, dst, reg_wr_vld, load_op, dmenbl, dmdatain} !==
        {m_rslt, m_flags, m_dst, 1'b0, 1'b0, 1'b0, 8'h77}) begin
      errors++; $display("FAIL st_no_wb: got rslt=%h flags=%b wr=%b ld=%b en=%b data=%h want %h %b 0 0 0 77",
                         rslt, flags, reg_wr_vld, load_op, dmenbl, dmdatain, m_rslt, m_flags);
    end
    tick(1'b1);
    checks++;
    if ({dmenbl, reg_wr_vld, load_op, mem_err, in_rdy} !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL ack_in_run: got en=%b wr=%b ld=%b err=%b rdy=%b want 0 0 0 0 1",
                         dmenbl, reg_wr_vld, load_op, mem_err, in_rdy);
    end
    dm_ack = 1'b0;
    alu_op(OP_NEG, 8'h80, 8'h00, 3'd1);
    checks++;
    if ({rslt, flags, dst, reg_wr_vld} !== {m_rslt, m_flags, m_dst, 1'b1}) begin
      errors++; $display("FAIL neg_80: got rslt=%h flags=%b want %h %b", rslt, flags, m_rslt, m_flags);
    end
  endtask

  initial begin
    test_reset();
    test_alu_directed();
    test_back_to_back();
    test_random_alu();
    test_load();
    test_store_timeout();
    test_reset_in_mem();
    test_nop_st_ack();
    test_random_alu();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
